tone_period_meter: RTL and testbench

Measures the period and high time of an incoming square-wave tone in `clk` cycles. It averages the result over 2^AVG_LOG2 consecutive periods. It is the receive-side counterpart of the team's tone divider: it recovers the timing of a divided tone, for pitch verification, for the tuner display, and for closed-loop checks of the divider setting. It sits between an external or loop-back tone pin and the control logic that reads `period`/`high_time`.

---
 rtl/tone_pkg.sv | 11 +
 rtl/sync_edge.sv | 31 +++
 rtl/tone_period_meter.sv | 161 ++++++++++++++++
 tb/tb_tone_period_meter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - shared tone constants and FSM state codes
package tone_pkg;

   localparam int TONE_CNT_W   = 32;
   localparam int TONE_TIMEOUT = 1_000_000;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ARM  = 2'd1;
   localparam logic [1:0] ST_MEAS = 2'd2;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - two-flop synchronizer with delayed copy and rise/fall strobes
module sync_edge (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic d_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic sync_dly_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         meta_q     <= 1'b0;
         sync_q     <= 1'b0;
         sync_dly_q <= 1'b0;
      end else begin
         meta_q     <= d_i;
         sync_q     <= meta_q;
         sync_dly_q <= sync_q;
      end
   end

   assign sync_o = sync_q;
   assign rise_o = sync_q & ~sync_dly_q;
   assign fall_o = ~sync_q & sync_dly_q;

endmodule

// File: rtl/tone_period_meter.sv
// rtl/tone_period_meter.sv - averaged period / high-time meter for a square-wave tone
module tone_period_meter
   import tone_pkg::*;
#(
   parameter int CNT_W    = TONE_CNT_W,
   parameter int AVG_LOG2 = 2,
   parameter int TIMEOUT  = TONE_TIMEOUT
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             en_i,
   input  logic             tone_in_i,
   output logic [CNT_W-1:0] period_o,
   output logic [CNT_W-1:0] high_time_o,
   output logic             valid_o,
   output logic             no_tone_o
);

   localparam int                ACC_W     = CNT_W + AVG_LOG2;
   localparam int                NPER_W    = AVG_LOG2 + 1;
   localparam logic [CNT_W-1:0]  TO_CNT    = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0]  ARM_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [NPER_W-1:0] NPER_LAST = NPER_W'((1 << AVG_LOG2) - 1);

   logic sync;
   logic rise;
   logic unused_fall;

   sync_edge u_sync (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .d_i     (tone_in_i),
      .sync_o  (sync),
      .rise_o  (rise),
      .fall_o  (unused_fall)
   );

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  hcnt_q, hcnt_d;
   logic [ACC_W-1:0]  acc_p_q, acc_p_d;
   logic [ACC_W-1:0]  acc_h_q, acc_h_d;
   logic [NPER_W-1:0] nper_q, nper_d;
   logic [CNT_W-1:0]  period_q, period_d;
   logic [CNT_W-1:0]  high_q, high_d;
   logic              valid_q, valid_d;
   logic              no_tone_q, no_tone_d;
   logic [ACC_W-1:0]  sum_p;
   logic [ACC_W-1:0]  sum_h;

   // Batch totals including the period closing at this rise.
   assign sum_p = acc_p_q + ACC_W'(cnt_q);
   assign sum_h = acc_h_q + ACC_W'(hcnt_q);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hcnt_d    = hcnt_q;
      acc_p_d   = acc_p_q;
      acc_h_d   = acc_h_q;
      nper_d    = nper_q;
      period_d  = period_q;
      high_d    = high_q;
      valid_d   = 1'b0;
      no_tone_d = no_tone_q;
      if (!en_i) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         hcnt_d  = '0;
         acc_p_d = '0;
         acc_h_d = '0;
         nper_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_ARM;
               cnt_d   = '0;
            end
            ST_ARM: begin
               // cnt doubles as the arming wait counter here.
               if (rise) begin
                  state_d = ST_MEAS;
                  cnt_d   = CNT_W'(1);
                  hcnt_d  = CNT_W'(1);
                  acc_p_d = '0;
                  acc_h_d = '0;
                  nper_d  = '0;
               end else if (cnt_q >= ARM_LAST) begin
                  no_tone_d = 1'b1;
                  cnt_d     = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_MEAS: begin
               if (rise) begin
                  cnt_d  = CNT_W'(1);
                  hcnt_d = CNT_W'(1);
                  if (nper_q == NPER_LAST) begin
                     period_d  = CNT_W'(sum_p >> AVG_LOG2);
                     high_d    = CNT_W'(sum_h >> AVG_LOG2);
                     valid_d   = 1'b1;
                     no_tone_d = 1'b0;
                     acc_p_d   = '0;
                     acc_h_d   = '0;
                     nper_d    = '0;
                  end else begin
                     acc_p_d = sum_p;
                     acc_h_d = sum_h;
                     nper_d  = nper_q + 1'b1;
                  end
               end else if (cnt_q == TO_CNT) begin
                  state_d   = ST_ARM;
                  no_tone_d = 1'b1;
                  cnt_d     = '0;
                  hcnt_d    = '0;
                  acc_p_d   = '0;
                  acc_h_d   = '0;
                  nper_d    = '0;
               end else begin
                  cnt_d  = cnt_q + 1'b1;
                  hcnt_d = hcnt_q + CNT_W'(sync);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         hcnt_q    <= '0;
         acc_p_q   <= '0;
         acc_h_q   <= '0;
         nper_q    <= '0;
         period_q  <= '0;
         high_q    <= '0;
         valid_q   <= 1'b0;
         no_tone_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hcnt_q    <= hcnt_d;
         acc_p_q   <= acc_p_d;
         acc_h_q   <= acc_h_d;
         nper_q    <= nper_d;
         period_q  <= period_d;
         high_q    <= high_d;
         valid_q   <= valid_d;
         no_tone_q <= no_tone_d;
      end
   end

   assign period_o    = period_q;
   assign high_time_o = high_q;
   assign valid_o     = valid_q;
   assign no_tone_o   = no_tone_q;

endmodule

// File: tb/tb_tone_period_meter.sv
// tb/tb_tone_period_meter.sv - self-checking bench for tone_period_meter
module tb_tone_period_meter;

   localparam int CNT_W    = 32;
   localparam int AVG_LOG2 = 2;
   localparam int TIMEOUT  = 1000;
   localparam int NAVG     = 1 << AVG_LOG2;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b0;
   logic             en    = 1'b0;
   logic             tone  = 1'b0;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic             valid;
   logic             no_tone;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int t_last_rise = 0;

   int rec_p[$];
   int rec_h[$];
   int rec_c[$];
   int rec_nt[$];
   int stim_p[$];
   int stim_h[$];
   int exp_p[$];
   int exp_h[$];

   tone_period_meter #(
      .CNT_W    (CNT_W),
      .AVG_LOG2 (AVG_LOG2),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .en_i        (en),
      .tone_in_i   (tone),
      .period_o    (period),
      .high_time_o (high_time),
      .valid_o     (valid),
      .no_tone_o   (no_tone)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid === 1'b1) begin
         rec_p.push_back(int'(period));
         rec_h.push_back(int'(high_time));
         rec_c.push_back(cyc);
         rec_nt.push_back(int'(no_tone));
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic clear_rec();
      rec_p.delete(); rec_h.delete(); rec_c.delete(); rec_nt.delete();
   endtask

   task automatic drive_period(input int p, input int h);
      tone = 1'b1;
      repeat (h) @(negedge clk);
      tone = 1'b0;
      repeat (p - h) @(negedge clk);
   endtask

   task automatic rearm();
      en = 1'b0;
      repeat (3) @(negedge clk);
      en = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   // Plays every stimulus period, then one closing rising edge.
   task automatic play();
      foreach (stim_p[i]) drive_period(stim_p[i], stim_h[i]);
      t_last_rise = cyc;
      tone = 1'b1;
      @(negedge clk);
      tone = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   // Reference: each full group of NAVG periods yields the truncated mean.
   task automatic build_expected();
      int sp, sh;
      exp_p.delete(); exp_h.delete();
      for (int b = 0; b + NAVG <= stim_p.size(); b += NAVG) begin
         sp = 0; sh = 0;
         for (int k = 0; k < NAVG; k++) begin
            sp += stim_p[b+k];
            sh += stim_h[b+k];
         end
         exp_p.push_back(sp / NAVG);
         exp_h.push_back(sh / NAVG);
      end
   endtask

   task automatic set_const(input int n, input int p, input int h);
      stim_p.delete(); stim_h.delete();
      for (int i = 0; i < n; i++) begin
         stim_p.push_back(p);
         stim_h.push_back(h);
      end
   endtask

   task automatic test_reset();
      @(negedge clk); #1;
      total++; if (period !== '0) begin bad++; $display("FAIL reset_period: got %0d expected 0", period); end
      total++; if (high_time !== '0) begin bad++; $display("FAIL reset_high: got %0d expected 0", high_time); end
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", valid); end
      total++; if (no_tone !== 1'b0) begin bad++; $display("FAIL reset_no_tone: got %b expected 0", no_tone); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_steady();
      rearm(); clear_rec();
      set_const(8, 100, 50);
      build_expected();
      play();
      total++; if (rec_p.size() !== exp_p.size()) begin bad++; $display("FAIL steady_count: got %0d expected %0d", rec_p.size(), exp_p.size()); end
      for (int i = 0; i < exp_p.size() && i < rec_p.size(); i++) begin
         total++; if (rec_p[i] !== exp_p[i]) begin bad++; $display("FAIL steady_period[%0d]: got %0d expected %0d", i, rec_p[i], exp_p[i]); end
         total++; if (rec_h[i] !== exp_h[i]) begin bad++; $display("FAIL steady_high[%0d]: got %0d expected %0d", i, rec_h[i], exp_h[i]); end
         total++; if (rec_nt[i] !== 0) begin bad++; $display("FAIL steady_no_tone[%0d]: got %0d expected 0", i, rec_nt[i]); end
      end
      if (rec_c.size() >= 2) begin
         total++; if (rec_c[1] - rec_c[0] !== 400) begin bad++; $display("FAIL steady_interval: got %0d expected 400", rec_c[1] - rec_c[0]); end
      end
   endtask

   task automatic test_reset_mid();
      rearm(); clear_rec();
      drive_period(100, 50);
      tone = 1'b1;
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++; if (period !== '0) begin bad++; $display("FAIL midreset_period: got %0d expected 0", period); end
      total++; if (high_time !== '0) begin bad++; $display("FAIL midreset_high: got %0d expected 0", high_time); end
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL midreset_valid: got %b expected 0", valid); end
      total++; if (no_tone !== 1'b0) begin bad++; $display("FAIL midreset_no_tone: got %b expected 0", no_tone); end
      repeat (30) @(negedge clk);
      tone = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      set_const(4, 100, 50);
      foreach (stim_p[i]) drive_period(stim_p[i], stim_h[i]);
      total++; if (rec_p.size() !== 0) begin bad++; $display("FAIL midreset_early_valid: got %0d expected 0", rec_p.size()); end
      stim_p.delete(); stim_h.delete();
      play();
      total++; if (rec_p.size() !== 1) begin bad++; $display("FAIL midreset_count: got %0d expected 1", rec_p.size()); end
      if (rec_p.size() >= 1) begin
         total++; if (rec_p[0] !== 100) begin bad++; $display("FAIL midreset_period_val: got %0d expected 100", rec_p[0]); end
         total++; if (rec_h[0] !== 50) begin bad++; $display("FAIL midreset_high_val: got %0d expected 50", rec_h[0]); end
      end
   endtask

   task automatic test_averaging();
      rearm(); clear_rec();
      stim_p = '{100, 101, 101, 101};
      stim_h = '{50, 50, 51, 51};
      build_expected();
      play();
      total++; if (rec_p.size() !== 1) begin bad++; $display("FAIL avg_count: got %0d expected 1", rec_p.size()); end
      if (rec_p.size() >= 1) begin
         total++; if (rec_p[0] !== exp_p[0]) begin bad++; $display("FAIL avg_period: got %0d expected %0d", rec_p[0], exp_p[0]); end
         total++; if (rec_h[0] !== exp_h[0]) begin bad++; $display("FAIL avg_high: got %0d expected %0d", rec_h[0], exp_h[0]); end
      end
   endtask

   task automatic test_random();
      int p;
      for (int r = 0; r < 3; r++) begin
         rearm(); clear_rec();
         stim_p.delete(); stim_h.delete();
         for (int i = 0; i < 2 * NAVG; i++) begin
            p = int'($urandom_range(40, 2));
            stim_p.push_back(p);
            stim_h.push_back(int'($urandom_range(p - 1, 1)));
         end
         build_expected();
         play();
         total++; if (rec_p.size() !== exp_p.size()) begin bad++; $display("FAIL rand%0d_count: got %0d expected %0d", r, rec_p.size(), exp_p.size()); end
         for (int i = 0; i < exp_p.size() && i < rec_p.size(); i++) begin
            total++; if (rec_p[i] !== exp_p[i]) begin bad++; $display("FAIL rand%0d_period[%0d]: got %0d expected %0d", r, i, rec_p[i], exp_p[i]); end
            total++; if (rec_h[i] !== exp_h[i]) begin bad++; $display("FAIL rand%0d_high[%0d]: got %0d expected %0d", r, i, rec_h[i], exp_h[i]); end
         end
      end
   endtask

   task automatic test_timeout();
      int delta;
      rearm(); clear_rec();
      set_const(NAVG + 2, 50, 25);
      build_expected();
      play();
      total++; if (rec_p.size() !== 1) begin bad++; $display("FAIL to_first_count: got %0d expected 1", rec_p.size()); end
      total++; if (no_tone !== 1'b0) begin bad++; $display("FAIL to_before: got %b expected 0", no_tone); end
      for (int i = 0; i < 1200 && no_tone !== 1'b1; i++) @(negedge clk);
      delta = cyc - t_last_rise;
      total++; if (no_tone !== 1'b1) begin bad++; $display("FAIL to_no_tone: got %b expected 1", no_tone); end
      total++; if (delta < 1000 || delta > 1004) begin bad++; $display("FAIL to_latency: got %0d expected 1000..1004", delta); end
      total++; if (rec_p.size() !== 1) begin bad++; $display("FAIL to_extra_valid: got %0d expected 1", rec_p.size()); end
      total++; if (period !== 32'd50) begin bad++; $display("FAIL to_period_hold: got %0d expected 50", period); end
      clear_rec();
      set_const(NAVG, 60, 20);
      build_expected();
      play();
      total++; if (rec_p.size() !== 1) begin bad++; $display("FAIL to_restart_count: got %0d expected 1", rec_p.size()); end
      if (rec_p.size() >= 1) begin
         total++; if (rec_p[0] !== exp_p[0]) begin bad++; $display("FAIL to_restart_period: got %0d expected %0d", rec_p[0], exp_p[0]); end
         total++; if (rec_nt[0] !== 0) begin bad++; $display("FAIL to_restart_no_tone: got %0d expected 0", rec_nt[0]); end
      end
   endtask

   task automatic test_enable_drop();
      int p;
      rearm(); clear_rec();
      drive_period(80, 40);
      drive_period(80, 40);
      en = 1'b0;
      repeat (5) @(negedge clk);
      en = 1'b1;
      repeat (4) @(negedge clk);
      stim_p.delete(); stim_h.delete();
      for (int i = 0; i < NAVG; i++) begin
         p = int'($urandom_range(90, 10));
         stim_p.push_back(p);
         stim_h.push_back(int'($urandom_range(p - 1, 1)));
      end
      build_expected();
      play();
      total++; if (rec_p.size() !== 1) begin bad++; $display("FAIL endrop_count: got %0d expected 1", rec_p.size()); end
      if (rec_p.size() >= 1) begin
         total++; if (rec_p[0] !== exp_p[0]) begin bad++; $display("FAIL endrop_period: got %0d expected %0d", rec_p[0], exp_p[0]); end
         total++; if (rec_h[0] !== exp_h[0]) begin bad++; $display("FAIL endrop_high: got %0d expected %0d", rec_h[0], exp_h[0]); end
      end
   endtask

   task automatic test_min_period();
      rearm(); clear_rec();
      set_const(2 * NAVG, 2, 1);
      build_expected();
      play();
      total++; if (rec_p.size() !== 2) begin bad++; $display("FAIL min_count: got %0d expected 2", rec_p.size()); end
      for (int i = 0; i < 2 && i < rec_p.size(); i++) begin
         total++; if (rec_p[i] !== 2) begin bad++; $display("FAIL min_period[%0d]: got %0d expected 2", i, rec_p[i]); end
         total++; if (rec_h[i] !== 1) begin bad++; $display("FAIL min_high[%0d]: got %0d expected 1", i, rec_h[i]); end
      end
      if (rec_c.size() >= 2) begin
         total++; if (rec_c[1] - rec_c[0] !== 8) begin bad++; $display("FAIL min_interval: got %0d expected 8", rec_c[1] - rec_c[0]); end
      end
   endtask

   initial begin
      test_reset();
      test_steady();
      test_reset_mid();
      test_averaging();
      test_random();
      test_timeout();
      test_enable_drop();
      test_min_period();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
